bp_branch_queue: RTL

- In-flight branch queue between fetch (bp predict side) and execute.
- Captures every used prediction (PC, predicted direction/target, GHR snapshot) in program order; accepts out-of-order resolutions from execute by tag.
- Drives bp training in order, one per cycle.
- On a misprediction, issues the bp GHR recover pulse and a fetch redirect, and squashes younger entries.

---
 rtl/bp_branch_queue_pkg.sv | 53 +++++
 rtl/bp_branch_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bp_branch_queue_pkg.sv
// Shared types for the in-flight branch queue and the branch-predictor train/recover interface.
`ifndef BP_BQ_DEPTH
`define BP_BQ_DEPTH 8
`endif
`ifndef BP_GH
`define BP_GH 4
`endif

package bp_branch_queue_pkg;

  localparam int BP_BQ_DEPTH = `BP_BQ_DEPTH;
  localparam int BP_GH       = `BP_GH;

  typedef logic [$clog2(BP_BQ_DEPTH)-1:0] BQ_TAG;

  typedef enum logic [1:0] {
    BQ_FREE,
    BQ_PENDING,
    BQ_RESOLVED
  } BQ_STATE;

  typedef struct packed {
    BQ_STATE          state;
    logic [31:0]      pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [BP_GH-1:0] ghr;
    logic             act_taken;
    logic [31:0]      act_target;
  } BQ_ENTRY;

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [BP_GH-1:0] ghr_snapshot;
    logic             actual_taken;
    logic [31:0]      actual_target;
  } BP_TRAIN_REQUEST;

  typedef struct packed {
    logic             pulse;
    logic [BP_GH-1:0] ghr_snapshot;
  } BP_RECOVER_REQUEST;

  // A taken branch with the right direction can still go to the wrong place.
  function automatic logic is_mispredict(input logic        pred_taken,
                                         input logic [31:0] pred_target,
                                         input logic        taken,
                                         input logic [31:0] target);
    return (taken != pred_taken) || (taken && (target != pred_target));
  endfunction

endpackage

// File: rtl/bp_branch_queue.sv
// In-flight branch queue: records predictions in program order, takes out-of-order
// resolutions, trains the predictor in order and raises recover/redirect on mispredicts.
module bp_branch_queue
  import bp_branch_queue_pkg::*;
#(
  parameter  int DEPTH    = BP_BQ_DEPTH,
  localparam int TAG_BITS = $clog2(DEPTH),
  localparam int GH       = BP_GH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                alloc_valid_i,
  input  logic [31:0]         alloc_pc_i,
  input  logic                alloc_pred_taken_i,
  input  logic [31:0]         alloc_pred_target_i,
  input  logic [GH-1:0]       alloc_ghr_i,
  output logic                alloc_ready_o,
  output logic [TAG_BITS-1:0] alloc_tag_o,
  input  logic                resolve_valid_i,
  input  logic [TAG_BITS-1:0] resolve_tag_i,
  input  logic                resolve_taken_i,
  input  logic [31:0]         resolve_target_i,
  output BP_TRAIN_REQUEST     train_req_o,
  output BP_RECOVER_REQUEST   recover_req_o,
  output logic                redirect_valid_o,
  output logic [31:0]         redirect_pc_o,
  output logic [TAG_BITS:0]   count_o
);

  BQ_ENTRY             r_entries [DEPTH];
  logic [TAG_BITS-1:0] r_head;
  logic [TAG_BITS-1:0] r_tail;
  logic [TAG_BITS:0]   r_count;
  BP_TRAIN_REQUEST     r_train;
  BP_RECOVER_REQUEST   r_recover;
  logic                r_redirect_valid;
  logic [31:0]         r_redirect_pc;

  logic                w_pop;
  logic                w_resolve;
  logic                w_mispredict;
  logic                w_alloc;
  logic [TAG_BITS-1:0] w_tag_ofs;
  logic [DEPTH-1:0]    w_squash;
  logic [TAG_BITS:0]   w_count_nxt;

  assign alloc_ready_o = reset_n && (r_count != (TAG_BITS+1)'(DEPTH));
  assign alloc_tag_o   = r_tail;

  assign w_pop        = (r_entries[r_head].state == BQ_RESOLVED);
  assign w_resolve    = resolve_valid_i && (r_entries[resolve_tag_i].state == BQ_PENDING);
  assign w_mispredict = w_resolve && is_mispredict(r_entries[resolve_tag_i].pred_taken,
                                                   r_entries[resolve_tag_i].pred_target,
                                                   resolve_taken_i, resolve_target_i);
  // An alloc that coincides with a redirect is on the wrong path.
  assign w_alloc      = alloc_valid_i && alloc_ready_o && !w_mispredict;
  assign w_tag_ofs    = resolve_tag_i - r_head;

  // Age is the distance from head; anything farther than the mispredicted tag is younger.
  always_comb begin
    // NOTE: default first so every path assigns w_squash and no latch is inferred.
    w_squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_squash[i] = w_mispredict && ((TAG_BITS'(i) - r_head) > w_tag_ofs);
    end
  end

  always_comb begin
    if (w_mispredict)
      w_count_nxt = {1'b0, w_tag_ofs} + (TAG_BITS+1)'(1) - (TAG_BITS+1)'(w_pop);
    else
      w_count_nxt = r_count + (TAG_BITS+1)'(w_alloc) - (TAG_BITS+1)'(w_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: only the state field needs reset; payload is never read while FREE.
      for (int i = 0; i < DEPTH; i++) r_entries[i].state <= BQ_FREE;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_train          <= '0;
      r_recover        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      // NOTE: non-blocking throughout; later writes to the same entry field win.
      r_train.valid <= w_pop;
      if (w_pop) begin
        r_train.pc            <= r_entries[r_head].pc;
        r_train.ghr_snapshot  <= r_entries[r_head].ghr;
        r_train.actual_taken  <= r_entries[r_head].act_taken;
        r_train.actual_target <= r_entries[r_head].act_taken ? r_entries[r_head].act_target : 32'd0;
        r_entries[r_head].state <= BQ_FREE;
        r_head <= r_head + 1'b1;
      end

      if (w_resolve) begin
        r_entries[resolve_tag_i].state      <= BQ_RESOLVED;
        r_entries[resolve_tag_i].act_taken  <= resolve_taken_i;
        r_entries[resolve_tag_i].act_target <= resolve_target_i;
      end

      r_recover.pulse  <= w_mispredict;
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) begin
        r_recover.ghr_snapshot <= {r_entries[resolve_tag_i].ghr[GH-2:0], resolve_taken_i};
        r_redirect_pc <= resolve_taken_i ? resolve_target_i : r_entries[resolve_tag_i].pc + 32'd4;
        r_tail        <= resolve_tag_i + 1'b1;
      end else if (w_alloc) begin
        r_entries[r_tail] <= '{state: BQ_PENDING, pc: alloc_pc_i, pred_taken: alloc_pred_taken_i,
                               pred_target: alloc_pred_target_i, ghr: alloc_ghr_i,
                               act_taken: 1'b0, act_target: 32'd0};
        r_tail <= r_tail + 1'b1;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (w_squash[i]) r_entries[i].state <= BQ_FREE;
      end

      r_count <= w_count_nxt;
    end
  end

  assign train_req_o      = r_train;
  assign recover_req_o    = r_recover;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;
  assign count_o          = r_count;

endmodule
